// File: rtl/serial_sub_pkg.sv
// Shared state encoding and elaboration-time helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake and operand/result bundle between controller and subtractor.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  ready, busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output ready, busy, done, diff, bout, ovf
   );

endinterface

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one full-subtractor cell and a borrow flop.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CntW = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_sh_q, a_sh_d;
   logic [WIDTH-1:0]  b_sh_q, b_sh_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              borrow_q, borrow_d;
   logic              a_msb_q, a_msb_d;
   logic              b_msb_q, b_msb_d;
   logic              bout_q, bout_d;
   logic              ovf_q, ovf_d;
   logic              cell_d, cell_bo;

   full_subtractor_cell u_cell (
      .x    (a_sh_q[0]),
      .y    (b_sh_q[0]),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_bo)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d  = StRun;
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               borrow_d = bus.bin;
               cnt_d    = '0;
               a_msb_d  = bus.a[WIDTH-1];
               b_msb_d  = bus.b[WIDTH-1];
            end
         end
         StRun: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            diff_d   = {cell_d, diff_q[WIDTH-1:1]};
            borrow_d = cell_bo;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               bout_d  = cell_bo;
               // Overflow only when operand signs differ and the result sign departs from a.
               ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.ready = (state_q == StIdle);
   assign bus.busy  = (state_q == StRun);
   assign bus.done  = (state_q == StDone);
   assign bus.diff  = diff_q;
   assign bus.bout  = bout_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   serial_subtractor_if #(.WIDTH(W)) bus_if ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin, output logic [W-1:0] md,
                                 output logic mbo, output logic mov);
      logic [W:0] u;
      int         s;
      u   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      md  = u[W-1:0];
      mbo = u[W];
      s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      mov = (s < -128) || (s > 127);
   endfunction

   // One full operation: launch, watch busy/latency, check result and its hold after done.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tbin, input logic [W-1:0] ed, input logic eb,
                         input logic eo);
      int lat;
      int busy_cnt;
      @(negedge clk);
      check({tag, "_ready"}, 32'(bus_if.ready), 32'd1);
      bus_if.start = 1'b1;
      bus_if.a     = ta;
      bus_if.b     = tbv;
      bus_if.bin   = tbin;
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.a     = W'($urandom);
      bus_if.b     = W'($urandom);
      bus_if.bin   = 1'($urandom);
      lat      = 1;
      busy_cnt = 0;
      while (!bus_if.done && lat < 40) begin
         if (bus_if.busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(W + 1));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      check({tag, "_diff"}, 32'(bus_if.diff), 32'(ed));
      check({tag, "_bout"}, 32'(bus_if.bout), 32'(eb));
      check({tag, "_ovf"}, 32'(bus_if.ovf), 32'(eo));
      @(negedge clk);
      check({tag, "_ready_after"}, 32'(bus_if.ready), 32'd1);
      check({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
      check({tag, "_diff_hold"}, 32'(bus_if.diff), 32'(ed));
   endtask

   initial begin
      logic [W-1:0] va [20];
      logic [W-1:0] vb [20];
      logic [W-1:0] md;
      logic         mbo, mov;
      logic [W-1:0] ra, rb;
      logic         rbin;
      int           done_at [$];
      int           done_seen;

      tests = 0;
      fails = 0;
      rst          = 1'b1;
      bus_if.start = 1'b0;
      bus_if.a     = '0;
      bus_if.b     = '0;
      bus_if.bin   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", 32'(bus_if.ready), 32'd1);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_done", 32'(bus_if.done), 32'd0);
      check("rst_diff", 32'(bus_if.diff), 32'd0);
      check("rst_bout", 32'(bus_if.bout), 32'd0);
      check("rst_ovf", 32'(bus_if.ovf), 32'd0);

      run_op("basic",  8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
      run_op("under",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op("negovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("posovf", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      run_op("binin",  8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);

      // start held high: only operands present at IDLE edges are taken
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_if.done) begin
            done_at.push_back(i);
            if (done_at.size() == 1) begin
               model(va[0], vb[0], 1'b0, md, mbo, mov);
               check("hold_diff0", 32'(bus_if.diff), 32'(md));
            end else begin
               model(va[10], vb[10], 1'b0, md, mbo, mov);
               check("hold_diff1", 32'(bus_if.diff), 32'(md));
            end
         end
         va[i] = W'(i * 17 + 3);
         vb[i] = W'(i * 5 + 1);
         bus_if.start = 1'b1;
         bus_if.a     = va[i];
         bus_if.b     = vb[i];
         bus_if.bin   = 1'b0;
      end
      @(negedge clk);
      bus_if.start = 1'b0;
      check("hold_done_count", 32'(done_at.size()), 32'd2);
      if (done_at.size() == 2) begin
         check("hold_first_done", 32'(done_at[0]), 32'd9);
         check("hold_spacing", 32'(done_at[1] - done_at[0]), 32'(W + 2));
      end
      repeat (2) @(negedge clk);

      // reset in the middle of a run
      bus_if.start = 1'b1;
      bus_if.a     = 8'h5A;
      bus_if.b     = 8'h3C;
      bus_if.bin   = 1'b0;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_busy_before", 32'(bus_if.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", 32'(bus_if.ready), 32'd1);
      check("midrst_busy", 32'(bus_if.busy), 32'd0);
      check("midrst_diff", 32'(bus_if.diff), 32'd0);
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus_if.done) done_seen++;
      end
      check("midrst_no_done", 32'(done_seen), 32'd0);
      run_op("restart", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rbin = 1'($urandom);
         model(ra, rb, rbin, md, mbo, mov);
         run_op("rand", ra, rb, rbin, md, mbo, mov);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
